selector_de_valores: RTL and testbench



---
 rtl/selector_pkg.sv | 26 ++
 rtl/antirrebote.sv | 50 +++++
 rtl/selector_de_valores.sv | 68 ++++++
 tb/tb_selector_de_valores.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/selector_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | selector_pkg : widths, defaults and wrap helper for the selector |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package selector_pkg;

    localparam int VALORF_W       = 3;
    localparam int VALORC_W       = 4;
    localparam int VALORF_MAX_DEF = 7;
    localparam int VALORC_MAX_DEF = 9;
    localparam int DEBOUNCE_DEF   = 250000;
    localparam int DEBOUNCE_SIM   = 4;

    // One step up or down with wrap between 0 and maximo.
    function automatic logic [3:0] paso(input logic [3:0] v,
                                        input logic [3:0] maximo,
                                        input logic       sube);
        if (sube)
            return (v == maximo) ? 4'd0 : v + 4'd1;
        else
            return (v == 4'd0) ? maximo : v - 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/antirrebote.sv
`default_nettype none
// +------------------------------------------------------------------+
// | antirrebote : synchroniser, debouncer and press-pulse generator  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module antirrebote #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic reset,
    input  logic boton_i,
    output logic pulso_o
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_deb;
    logic          r_deb_d;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
        end else begin
            r_sync1 <= boton_i;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Rising edge of the debounced level only; releases are silent.
    assign pulso_o = r_deb & ~r_deb_d;

endmodule
`default_nettype wire

// File: rtl/selector_de_valores.sv
`default_nettype none
// +------------------------------------------------------------------+
// | selector_de_valores : button-driven mode/value selector          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module selector_de_valores
    import selector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int VALORF_MAX      = VALORF_MAX_DEF,
    parameter int VALORC_MAX      = VALORC_MAX_DEF
) (
    input  logic                clk_i,
    input  logic                reset,
    input  logic                boton_modo_i,
    input  logic                boton_inc_i,
    input  logic                boton_dec_i,
    output logic                modo_o,
    output logic [VALORF_W-1:0] valorf_o,
    output logic [VALORC_W-1:0] valorC_o,
    output logic                cambio_o
);

    logic w_p_modo;
    logic w_p_inc;
    logic w_p_dec;

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_modo (
        .clk_i(clk_i), .reset(reset), .boton_i(boton_modo_i), .pulso_o(w_p_modo));
    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_inc (
        .clk_i(clk_i), .reset(reset), .boton_i(boton_inc_i), .pulso_o(w_p_inc));
    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_dec (
        .clk_i(clk_i), .reset(reset), .boton_i(boton_dec_i), .pulso_o(w_p_dec));

    logic                w_modo_n;
    logic [VALORF_W-1:0] w_f_n;
    logic [VALORC_W-1:0] w_c_n;

    // The step targets the field selected before any same-cycle toggle;
    // inc and dec together cancel out.
    always_comb begin
        w_modo_n = modo_o ^ w_p_modo;
        w_f_n    = valorf_o;
        w_c_n    = valorC_o;
        if (w_p_inc ^ w_p_dec) begin
            if (!modo_o)
                w_f_n = VALORF_W'(paso({1'b0, valorf_o}, 4'(VALORF_MAX), w_p_inc));
            else
                w_c_n = paso(valorC_o, 4'(VALORC_MAX), w_p_inc);
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            modo_o   <= 1'b0;
            valorf_o <= '0;
            valorC_o <= '0;
            cambio_o <= 1'b0;
        end else begin
            modo_o   <= w_modo_n;
            valorf_o <= w_f_n;
            valorC_o <= w_c_n;
            cambio_o <= (w_modo_n != modo_o) || (w_f_n != valorf_o) || (w_c_n != valorC_o);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_selector_de_valores.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_selector_de_valores : scoreboard bench for selector_de_valores|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_selector_de_valores;
    import selector_pkg::*;

    logic       clk_i = 1'b0;
    logic       reset = 1'b1;
    logic       boton_modo_i = 1'b0;
    logic       boton_inc_i  = 1'b0;
    logic       boton_dec_i  = 1'b0;
    logic       modo_o;
    logic [2:0] valorf_o;
    logic [3:0] valorC_o;
    logic       cambio_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];

    selector_de_valores #(.DEBOUNCE_CYCLES(DEBOUNCE_SIM)) dut (
        .clk_i(clk_i), .reset(reset),
        .boton_modo_i(boton_modo_i), .boton_inc_i(boton_inc_i), .boton_dec_i(boton_dec_i),
        .modo_o(modo_o), .valorf_o(valorf_o), .valorC_o(valorC_o), .cambio_o(cambio_o));

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each cambio_o pulse must match the next queued {modo,valorf,valorC}.
    always @(negedge clk_i) begin
        if (!reset && cambio_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cambio: got %h expected none",
                         {modo_o, valorf_o, valorC_o});
            end else begin
                check("scoreboard", {modo_o, valorf_o, valorC_o}, sb.pop_front());
            end
        end
    end

    // mask: [2]=modo [1]=inc [0]=dec
    task automatic press(input logic [2:0] mask, input int hold);
        @(negedge clk_i);
        {boton_modo_i, boton_inc_i, boton_dec_i} = mask;
        repeat (hold) @(negedge clk_i);
        {boton_modo_i, boton_inc_i, boton_dec_i} = 3'b000;
        repeat (10) @(negedge clk_i);
    endtask

    task automatic press_exp(input logic [2:0] mask, input logic m,
                             input logic [2:0] f, input logic [3:0] c);
        sb.push_back({m, f, c});
        press(mask, 10);
    endtask

    initial begin
        #12;
        check("reset_state", {cambio_o, modo_o, valorf_o, valorC_o}, 9'h0);
        @(negedge clk_i);
        reset = 1'b0;
        repeat (3) @(negedge clk_i);

        // 3-cycle glitch must be rejected
        press(3'b010, 3);
        check("glitch_valorf", {5'd0, valorf_o}, 8'd0);

        // 20-cycle press: value appears exactly at edge e6
        sb.push_back({1'b0, 3'd1, 4'd0});
        @(negedge clk_i);
        boton_inc_i = 1'b1;
        repeat (6) @(negedge clk_i);
        check("latency_e5", {5'd0, valorf_o}, 8'd0);
        @(negedge clk_i);
        check("latency_e6", {5'd0, valorf_o}, 8'd1);
        check("latency_cambio", {7'd0, cambio_o}, 8'd1);
        repeat (13) @(negedge clk_i);
        boton_inc_i = 1'b0;
        repeat (10) @(negedge clk_i);

        // asynchronous reset between clock edges
        @(posedge clk_i);
        #2 reset = 1'b1;
        #1 check("async_reset", {cambio_o, modo_o, valorf_o, valorC_o}, 9'h0);
        @(negedge clk_i);
        reset = 1'b0;
        repeat (3) @(negedge clk_i);

        // valorf wrap upward and downward
        for (int i = 1; i <= 8; i++)
            press_exp(3'b010, 1'b0, 3'(i % 8), 4'd0);
        press_exp(3'b001, 1'b0, 3'd7, 4'd0);

        // valorC wrap, valorf untouched
        press_exp(3'b100, 1'b1, 3'd7, 4'd0);
        for (int i = 1; i <= 10; i++)
            press_exp(3'b010, 1'b1, 3'd7, 4'(i % 10));
        press_exp(3'b001, 1'b1, 3'd7, 4'd9);

        // inc and dec together: no change
        press(3'b011, 20);
        check("incdec_hold", {modo_o, valorf_o, valorC_o}, {1'b1, 3'd7, 4'd9});

        // reach modo=0, valorf=2, then modo+inc together
        press_exp(3'b100, 1'b0, 3'd7, 4'd9);
        press_exp(3'b010, 1'b0, 3'd0, 4'd9);
        press_exp(3'b010, 1'b0, 3'd1, 4'd9);
        press_exp(3'b010, 1'b0, 3'd2, 4'd9);
        press_exp(3'b110, 1'b1, 3'd3, 4'd9);

        // button held through reset counts once as a fresh press
        @(negedge clk_i);
        boton_inc_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #2 reset = 1'b1;
        #1 check("held_reset", {cambio_o, modo_o, valorf_o, valorC_o}, 9'h0);
        sb.push_back({1'b0, 3'd1, 4'd0});
        @(negedge clk_i);
        reset = 1'b0;
        repeat (6) @(negedge clk_i);
        check("held_e5", {5'd0, valorf_o}, 8'd0);
        @(negedge clk_i);
        check("held_e6", {5'd0, valorf_o}, 8'd1);
        repeat (30) @(negedge clk_i);
        check("held_no_repeat", {modo_o, valorf_o, valorC_o}, {1'b0, 3'd1, 4'd0});
        boton_inc_i = 1'b0;
        repeat (10) @(negedge clk_i);

        check("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
